// File: rtl/avalon_pwm_dt.sv
// Avalon-MM PWM controller: programmable period, edge/centre counting, shadowed
// PERIOD/MODE/DUTY, complementary outputs with dead-time, and W1C interrupt status.
module avalon_pwm_dt #(
  parameter int unsigned CLK_PRESCALER_WIDTH = 16,
  parameter int unsigned PWM_COUNTER_WIDTH   = 16,
  parameter int unsigned PWM_CHANNELS        = 4,
  parameter int unsigned DEADTIME_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic [5:0]              address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic                    irq,
  output logic [PWM_CHANNELS-1:0] pwm_out_h,
  output logic [PWM_CHANNELS-1:0] pwm_out_l
);

  localparam int unsigned PW = CLK_PRESCALER_WIDTH;
  localparam int unsigned CW = PWM_COUNTER_WIDTH;
  localparam int unsigned NC = PWM_CHANNELS;
  localparam int unsigned DW = DEADTIME_WIDTH;

  logic [PW-1:0] prescale_q, presc_cnt_q;
  logic [CW-1:0] period_q, period_act_q, count_q, count_d;
  logic [4:0]    ctrl_q;
  logic [1:0]    status_q, w1c;
  logic [DW-1:0] deadtime_q;
  logic [NC-1:0] polarity_q, raw, raw_q, h, l;
  logic [CW-1:0] duty_q [NC];
  logic [CW-1:0] duty_act_q [NC];
  logic [DW-1:0] dt_cnt_q [NC];
  logic [DW-1:0] dt_cnt_d [NC];
  logic          mode_act_q, dir_down_q, dir_down_d;
  logic          tick, period_evt, top_evt, wr_en, out_ena, cnt_ena;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign wr_en       = chipselect && write;
  assign out_ena     = ctrl_q[0];
  assign cnt_ena     = ctrl_q[1];
  assign unused_bits = ^writedata;
  // >= keeps the prescaler from running the long way round if PRESCALE shrinks
  assign tick        = cnt_ena && (presc_cnt_q >= prescale_q);
  assign w1c         = (wr_en && address == 6'd3) ? writedata[1:0] : 2'b00;

  always_comb begin
    count_d    = count_q;
    dir_down_d = dir_down_q;
    period_evt = 1'b0;
    top_evt    = 1'b0;
    if (tick) begin
      if (period_act_q == '0) begin
        count_d    = '0;
        period_evt = 1'b1;
      end else if (!mode_act_q) begin
        if (count_q >= period_act_q) begin
          count_d    = '0;
          period_evt = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (!dir_down_q) begin
        if (count_q >= period_act_q) begin
          count_d    = period_act_q - 1'b1;
          dir_down_d = 1'b1;
          top_evt    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (count_q == '0) begin
        count_d    = CW'(1);
        period_evt = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
      if (period_evt) dir_down_d = 1'b0;
    end
  end

  // Dead-time: the gap starts in the same cycle as the raw edge.
  always_comb begin
    for (int unsigned i = 0; i < NC; i++) begin
      raw[i]      = count_q < duty_act_q[i];
      dt_cnt_d[i] = dt_cnt_q[i];
      if (!out_ena) begin
        dt_cnt_d[i] = '0;
      end else if (raw[i] != raw_q[i]) begin
        dt_cnt_d[i] = deadtime_q;
      end else if (dt_cnt_q[i] != '0) begin
        dt_cnt_d[i] = dt_cnt_q[i] - 1'b1;
      end
      h[i] = raw[i] && (dt_cnt_d[i] == '0);
      l[i] = !raw[i] && (dt_cnt_d[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      period_q   <= '0;
      ctrl_q     <= 5'h03;
      deadtime_q <= '0;
      polarity_q <= '0;
      for (int unsigned i = 0; i < NC; i++) duty_q[i] <= '0;
    end else if (wr_en) begin
      case (address)
        6'd0:    prescale_q <= writedata[PW-1:0];
        6'd1:    period_q   <= writedata[CW-1:0];
        6'd2:    ctrl_q     <= writedata[4:0];
        6'd4:    deadtime_q <= writedata[DW-1:0];
        6'd5:    polarity_q <= writedata[NC-1:0];
        default: ;
      endcase
      for (int unsigned i = 0; i < NC; i++) begin
        if (address == 6'(32 + i)) duty_q[i] <= writedata[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c) | {top_evt, period_evt};
      irq      <= |(status_q & ctrl_q[4:3]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt_q  <= '0;
      count_q      <= '0;
      dir_down_q   <= 1'b0;
      period_act_q <= '0;
      mode_act_q   <= 1'b0;
      raw_q        <= '0;
      pwm_out_h    <= '0;
      pwm_out_l    <= '0;
      for (int unsigned i = 0; i < NC; i++) begin
        duty_act_q[i] <= '0;
        dt_cnt_q[i]   <= '0;
      end
    end else begin
      if (cnt_ena) presc_cnt_q <= tick ? '0 : presc_cnt_q + 1'b1;
      count_q    <= count_d;
      dir_down_q <= dir_down_d;
      if (period_evt || !cnt_ena) begin
        period_act_q <= period_q;
        mode_act_q   <= ctrl_q[2];
        for (int unsigned i = 0; i < NC; i++) duty_act_q[i] <= duty_q[i];
      end
      raw_q     <= raw;
      pwm_out_h <= ({NC{out_ena}} & h) ^ polarity_q;
      pwm_out_l <= ({NC{out_ena}} & l) ^ polarity_q;
      for (int unsigned i = 0; i < NC; i++) dt_cnt_q[i] <= dt_cnt_d[i];
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      6'd0: rdata = 32'(prescale_q);
      6'd1: rdata = 32'(period_q);
      6'd2: rdata = 32'(ctrl_q);
      6'd3: rdata = 32'(status_q);
      6'd4: rdata = 32'(deadtime_q);
      6'd5: rdata = 32'(polarity_q);
      6'd6: rdata = 32'(count_q);
      default: begin
        for (int unsigned i = 0; i < NC; i++) begin
          if (address == 6'(32 + i)) rdata = 32'(duty_q[i]);
        end
      end
    endcase
    readdata = (chipselect && read) ? rdata : '0;
  end

endmodule
